// File: rtl/sdram_client.sv
// Host valid/ready to sdram_bus toggle-handshake endpoint: one outstanding transaction,
// one-cycle response pulse, idle refresh hint. Optional one-entry read cache: SDRAM_CLIENT_READ_CACHE_EN.
module sdram_client #(
    parameter int ADDR_BITS           = 22,
    parameter int IDLE_REFRESH_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [15:0]          host_wdata,
    output logic                 rsp_valid,
    output logic [15:0]          rsp_rdata,
    output logic                 req,
    input  logic                 ack,
    output logic                 we,
    output logic [ADDR_BITS-1:0] address,
    output logic [15:0]          data_write,
    input  logic [15:0]          data_read,
    output logic                 refresh
);

    localparam int CNT_W = $clog2(IDLE_REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_REFRESH_CYCLES);

    typedef enum logic [1:0] {SYNC, IDLE, WAIT_ACK} state_t;

    state_t           state, state_n;
    logic             host_ready_n;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
    logic             accept, hit, issue, done;

    assign accept = (state == IDLE) && host_valid && host_ready;
    assign issue  = accept && !hit;
    assign done   = (state == WAIT_ACK) && (ack == req);

`ifdef SDRAM_CLIENT_READ_CACHE_EN
    logic                 cache_vld;
    logic [ADDR_BITS-1:0] cache_tag;
    logic [15:0]          cache_data;

    assign hit = accept && !host_we && cache_vld && (cache_tag == host_addr);

    // Cache is emptied whenever the link resynchronises; writes to the tag update it at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_data <= '0;
        end else if (state == SYNC) begin
            cache_vld <= 1'b0;
        end else if (done && !we) begin
            cache_vld  <= 1'b1;
            cache_tag  <= address;
            cache_data <= data_read;
        end else if (accept && host_we && cache_vld && (cache_tag == host_addr)) begin
            cache_data <= host_wdata;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        host_ready_n = 1'b0;
        idle_cnt_n   = '0;
        case (state)
            SYNC: begin
                // A toggle left in flight across reset must land before new traffic.
                if (ack == req) begin
                    state_n      = IDLE;
                    host_ready_n = 1'b1;
                end
            end
            IDLE: begin
                host_ready_n = !issue;
                if (issue)
                    state_n = WAIT_ACK;
                if (accept)
                    idle_cnt_n = '0;
                else if (!host_valid)
                    idle_cnt_n = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
                else
                    idle_cnt_n = idle_cnt;
            end
            WAIT_ACK: begin
                if (done)
                    state_n = IDLE;
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            host_ready <= 1'b0;
            idle_cnt   <= '0;
            refresh    <= 1'b0;
            req        <= 1'b0;
            we         <= 1'b0;
            address    <= '0;
            data_write <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_n;
            host_ready <= host_ready_n;
            idle_cnt   <= idle_cnt_n;
            refresh    <= (state_n == IDLE) && (idle_cnt_n == CNT_MAX);
            rsp_valid  <= done || hit;
            if (issue) begin
                req     <= ~req;
                we      <= host_we;
                address <= host_addr;
                if (host_we)
                    data_write <= host_wdata;
            end
            // data_read is live DQ, so it is only meaningful on the matching edge.
            if (done && !we)
                rsp_rdata <= data_read;
`ifdef SDRAM_CLIENT_READ_CACHE_EN
            else if (hit)
                rsp_rdata <= cache_data;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_client.sv
// Directed bench for sdram_client: handshake latency, hold, refresh hint, reset resync, cache hit.
module tb_sdram_client;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_we = 1'b0;
    logic [21:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        req;
    logic        ack = 1'b0;
    logic        we;
    logic [21:0] address;
    logic [15:0] data_write;
    logic [15:0] data_read = '0;
    logic        refresh;

    int tests = 0;
    int fails = 0;
    int rsp_cnt = 0;
    logic        exp_req = 1'b0;
    logic [15:0] exp_rdata = '0;
    logic [15:0] exp_wd = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;

    sdram_client #(.ADDR_BITS(22), .IDLE_REFRESH_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .req(req), .ack(ack), .we(we), .address(address),
        .data_write(data_write), .data_read(data_read), .refresh(refresh)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // req may only toggle on an edge where the previous handshake had completed.
    always @(negedge clk) begin
        if (!reset && req !== prev_req)
            chk1("req_toggle_while_busy", prev_ack, prev_req);
        if (rsp_valid)
            rsp_cnt++;
        prev_req = req;
        prev_ack = ack;
    end

    // One full transaction: accept, wait dly cycles, toggle ack, check response.
    task automatic xact(input logic w, input logic [21:0] a, input logic [15:0] wd,
                        input int dly, input logic [15:0] rd);
        host_valid = 1'b1; host_we = w; host_addr = a; host_wdata = wd;
        step;
        host_valid = 1'b0; host_we = ~w; host_addr = ~a; host_wdata = ~wd;
        exp_req = ~exp_req;
        if (w) exp_wd = wd;
        chk1("req_toggled", req, exp_req);
        chk1("ready_low", host_ready, 1'b0);
        chk1("refresh_drop", refresh, 1'b0);
        for (int k = 0; k < dly; k++) begin
            chk1("no_early_rsp", rsp_valid, 1'b0);
            chk1("we_hold", we, w);
            chkw("addr_hold", 32'(address), 32'(a));
            chkw("wdata_hold", 32'(data_write), 32'(exp_wd));
            step;
        end
        ack = ~ack;
        data_read = rd;
        step;
        data_read = ~rd;
        if (!w) exp_rdata = rd;
        chk1("rsp_pulse", rsp_valid, 1'b1);
        chkw("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        chk1("ready_low_on_rsp", host_ready, 1'b0);
        step;
        chk1("rsp_one_cycle", rsp_valid, 1'b0);
        chk1("ready_back", host_ready, 1'b1);
        chkw("rsp_rdata_kept", 32'(rsp_rdata), 32'(exp_rdata));
        chk1("req_stable", req, exp_req);
    endtask

    initial begin
        #1 reset = 1'b1;
        step; step;
        chk1("rst_req", req, 1'b0);
        chk1("rst_we", we, 1'b0);
        chkw("rst_addr", 32'(address), 32'h0);
        chkw("rst_wdata", 32'(data_write), 32'h0);
        chk1("rst_refresh", refresh, 1'b0);
        chk1("rst_ready", host_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chkw("rst_rdata", 32'(rsp_rdata), 32'h0);
        reset = 1'b0;
        step;
        chk1("sync_exit_ready", host_ready, 1'b1);

        // Read 0x00123, ack after 6 cycles with 0xBEEF.
        xact(1'b0, 22'h00123, 16'h0000, 6, 16'hBEEF);

        // Response cycle was idle cycle 1; hint must appear on cycle 17.
        chk1("refresh_c2", refresh, 1'b0);
        repeat (14) step;
        chk1("refresh_c16", refresh, 1'b0);
        step;
        chk1("refresh_c17", refresh, 1'b1);

        // Write at the top address while refresh is high.
        xact(1'b1, 22'h3FFFFF, 16'h1234, 3, 16'h7777);

`ifdef SDRAM_CLIENT_READ_CACHE_EN
        xact(1'b0, 22'h00010, 16'h0000, 2, 16'hA5A5);
        xact(1'b1, 22'h00010, 16'h5A5A, 2, 16'h0000);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 22'h00010;
        step;
        exp_rdata = 16'h5A5A;
        chk1("hit_no_req", req, exp_req);
        chk1("hit_rsp", rsp_valid, 1'b1);
        chkw("hit_data", 32'(rsp_rdata), 32'h5A5A);
        chk1("hit_ready", host_ready, 1'b1);
        step;
        chk1("hit2_rsp", rsp_valid, 1'b1);
        chk1("hit2_no_req", req, exp_req);
        host_valid = 1'b0;
        step;
        chk1("hit_rsp_end", rsp_valid, 1'b0);
`else
        xact(1'b0, 22'h00010, 16'h0000, 2, 16'hA5A5);
        xact(1'b1, 22'h00010, 16'h5A5A, 2, 16'h0000);
        xact(1'b0, 22'h00010, 16'h0000, 2, 16'h5A5A);
`endif

        // Reset during a read whose toggle drives req 1->0 while ack is still 1.
        if (exp_req == 1'b0)
            xact(1'b0, 22'h00200, 16'h0000, 1, 16'h0F0F);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 22'h00321;
        step;
        host_valid = 1'b0;
        exp_req = 1'b0;
        chk1("pre_rst_req", req, 1'b0);
        reset = 1'b1;
        #1;
        chk1("mid_rst_ready", host_ready, 1'b0);
        chk1("mid_rst_we", we, 1'b0);
        step; step;
        reset = 1'b0;
        exp_wd = 16'h0000;
        exp_rdata = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            step;
            chk1("sync_hold_ready", host_ready, 1'b0);
            chk1("sync_no_req", req, 1'b0);
        end
        ack = ~ack;
        step;
        chk1("sync_done_ready", host_ready, 1'b1);
        chk1("sync_done_req", req, 1'b0);
        step;

        // Back-to-back reads with random ack delays.
        rsp_cnt = 0;
        for (int i = 0; i < 5; i++)
            xact(1'b0, 22'h01000 + 22'(i), 16'h0000, int'($urandom_range(1, 20)),
                 16'hC000 + 16'(i * 16'h0111));
        chkw("rsp_count", 32'(rsp_cnt), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
